knn_nn_list: RTL and testbench

- Downstream consumer of the distance core.
- For one test point it receives a stream of (distance, label) pairs and keeps the NBR_KNN smallest distances in an ascending sorted list.
- On request it runs a majority vote over the labels of the kept neighbours and outputs the classified label.
- Cleared between test points by the controller.

---
 rtl/knn_pkg.sv | 25 ++
 rtl/knn_vote.sv | 119 +++++++++++
 rtl/knn_nn_list.sv | 138 +++++++++++++
 tb/tb_knn_nn_list.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | knn_pkg : shared widths, limits and vote FSM encoding for the k-NN list |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package knn_pkg;

  localparam int KNN_DATA_W  = 32;
  localparam int KNN_LABEL_W = 8;

  localparam logic [KNN_DATA_W-1:0] DIST_MAX = '1;

  // Index width covers up to 16 slots / labels; counters reach 16 without wrapping.
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PICK  = 2'd2,
    ST_DONE  = 2'd3
  } vote_state_e;

endpackage
`default_nettype wire

// File: rtl/knn_vote.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | knn_vote : majority vote over the kept neighbour labels (COUNT/PICK)  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module knn_vote
  import knn_pkg::*;
#(
  parameter int LABEL_W    = KNN_LABEL_W,
  parameter int NBR_KNN    = 4,
  parameter int NBR_LABELS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               start_i,
  output logic [IDX_W-1:0]   rd_idx_o,
  input  logic [LABEL_W-1:0] rd_lbl_i,
  input  logic               rd_vld_i,
  output logic [LABEL_W-1:0] label_o,
  output logic               label_valid_o,
  output logic               busy_o
);

  vote_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q [NBR_LABELS];
  logic [CNT_W-1:0]   cnt_d [NBR_LABELS];
  logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
  logic [LABEL_W-1:0] best_lbl_q, best_lbl_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic [CNT_W-1:0]   w_cur_cnt;

  // idx doubles as the slot index in COUNT and the label index in PICK.
  always_comb begin
    w_cur_cnt = '0;
    for (int l = 0; l < NBR_LABELS; l++) begin
      if (idx_q == IDX_W'(l)) w_cur_cnt = cnt_q[l];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    best_cnt_d = best_cnt_q;
    best_lbl_d = best_lbl_q;
    label_d    = label_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_COUNT;
          idx_d      = '0;
          best_cnt_d = '0;
          best_lbl_d = '0;
          for (int l = 0; l < NBR_LABELS; l++) cnt_d[l] = '0;
        end
      end
      ST_COUNT: begin
        // Out-of-range labels match no counter and are silently ignored.
        if (rd_vld_i) begin
          for (int l = 0; l < NBR_LABELS; l++) begin
            if (rd_lbl_i == LABEL_W'(l)) cnt_d[l] = cnt_q[l] + 1'b1;
          end
        end
        if (idx_q == IDX_W'(NBR_KNN - 1)) begin
          state_d = ST_PICK;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_PICK: begin
        if (w_cur_cnt > best_cnt_q) begin
          best_cnt_d = w_cur_cnt;
          best_lbl_d = LABEL_W'(idx_q);
        end
        if (idx_q == IDX_W'(NBR_LABELS - 1)) begin
          state_d = ST_DONE;
          idx_d   = '0;
          label_d = best_lbl_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clr_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      best_cnt_q <= '0;
      best_lbl_q <= '0;
      label_q    <= '0;
      for (int l = 0; l < NBR_LABELS; l++) cnt_q[l] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_cnt_q <= best_cnt_d;
      best_lbl_q <= best_lbl_d;
      label_q    <= label_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rd_idx_o      = idx_q;
  assign label_o       = label_q;
  assign label_valid_o = (state_q == ST_DONE);
  assign busy_o        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/knn_nn_list.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | knn_nn_list : sorted K-smallest (distance,label) list with label vote |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module knn_nn_list
  import knn_pkg::*;
#(
  parameter int DATA_W     = KNN_DATA_W,
  parameter int LABEL_W    = KNN_LABEL_W,
  parameter int NBR_KNN    = 4,
  parameter int NBR_LABELS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en_list,
  input  logic [DATA_W-1:0]  dist_entry,
  input  logic [LABEL_W-1:0] label_entry,
  input  logic               vote,
  output logic               ready,
  output logic [4:0]         nn_cnt,
  output logic [DATA_W-1:0]  worst_dist,
  output logic [LABEL_W-1:0] label_out,
  output logic               label_valid
);

  logic [DATA_W-1:0]  dist_q [NBR_KNN];
  logic [DATA_W-1:0]  dist_d [NBR_KNN];
  logic [LABEL_W-1:0] lbl_q  [NBR_KNN];
  logic [LABEL_W-1:0] lbl_d  [NBR_KNN];
  logic [NBR_KNN-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NBR_KNN-1:0] w_hit, w_first;
  logic               w_busy, w_ins, w_start;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [LABEL_W-1:0] w_rd_lbl;
  logic               w_rd_vld;

  assign ready   = ~w_busy;
  assign w_ins   = en_list & ready & ~clr;
  assign w_start = vote & ready & ~clr;

  // With a sorted, contiguous list the hit vector is a thermometer code,
  // so the insert point is simply its lowest set bit.
  always_comb begin
    w_hit   = '0;
    w_first = '0;
    for (int i = 0; i < NBR_KNN; i++) begin
      w_hit[i] = ~vld_q[i] | (dist_entry < dist_q[i]);
    end
    w_first[0] = w_hit[0];
    for (int i = 1; i < NBR_KNN; i++) begin
      w_first[i] = w_hit[i] & ~w_hit[i-1];
    end
  end

  always_comb begin
    dist_d = dist_q;
    lbl_d  = lbl_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    if (clr) begin
      vld_d = '0;
      cnt_d = '0;
      for (int i = 0; i < NBR_KNN; i++) begin
        dist_d[i] = {DATA_W{1'b1}};
        lbl_d[i]  = '0;
      end
    end else if (w_ins && (|w_hit)) begin
      for (int i = 1; i < NBR_KNN; i++) begin
        if (w_hit[i] && !w_first[i]) begin
          dist_d[i] = dist_q[i-1];
          lbl_d[i]  = lbl_q[i-1];
          vld_d[i]  = vld_q[i-1];
        end
      end
      for (int i = 0; i < NBR_KNN; i++) begin
        if (w_first[i]) begin
          dist_d[i] = dist_entry;
          lbl_d[i]  = label_entry;
          vld_d[i]  = 1'b1;
        end
      end
      if (!vld_q[NBR_KNN-1]) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < NBR_KNN; i++) begin
        dist_q[i] <= {DATA_W{1'b1}};
        lbl_q[i]  <= '0;
      end
    end else begin
      dist_q <= dist_d;
      lbl_q  <= lbl_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    w_rd_lbl = '0;
    w_rd_vld = 1'b0;
    for (int i = 0; i < NBR_KNN; i++) begin
      if (w_rd_idx == IDX_W'(i)) begin
        w_rd_lbl = lbl_q[i];
        w_rd_vld = vld_q[i];
      end
    end
  end

  assign nn_cnt     = cnt_q;
  assign worst_dist = vld_q[NBR_KNN-1] ? dist_q[NBR_KNN-1] : {DATA_W{1'b1}};

  knn_vote #(
    .LABEL_W   (LABEL_W),
    .NBR_KNN   (NBR_KNN),
    .NBR_LABELS(NBR_LABELS)
  ) u_vote (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .start_i      (w_start),
    .rd_idx_o     (w_rd_idx),
    .rd_lbl_i     (w_rd_lbl),
    .rd_vld_i     (w_rd_vld),
    .label_o      (label_out),
    .label_valid_o(label_valid),
    .busy_o       (w_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_knn_nn_list.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_knn_nn_list : directed and randomized bench with queue-based model |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_knn_nn_list;

  localparam int K  = 4;
  localparam int L  = 4;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam logic [DW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          en_list = 1'b0;
  logic          vote = 1'b0;
  logic [DW-1:0] dist_entry = '0;
  logic [LW-1:0] label_entry = '0;
  logic          ready, label_valid;
  logic [4:0]    nn_cnt;
  logic [DW-1:0] worst_dist;
  logic [LW-1:0] label_out;

  int checks = 0;
  int failures = 0;
  int unsigned md[$];
  int unsigned ml[$];

  always #5 clk = ~clk;

  knn_nn_list #(.DATA_W(DW), .LABEL_W(LW), .NBR_KNN(K), .NBR_LABELS(L)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en_list(en_list), .dist_entry(dist_entry),
    .label_entry(label_entry), .vote(vote), .ready(ready), .nn_cnt(nn_cnt),
    .worst_dist(worst_dist), .label_out(label_out), .label_valid(label_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: keep the K smallest distances, stable for ties (new goes after equals).
  function automatic void model_insert(int unsigned d, int unsigned l);
    int p;
    p = md.size();
    for (int i = 0; i < md.size(); i++) begin
      if (d < md[i]) begin
        p = i;
        break;
      end
    end
    if (p < K) begin
      md.insert(p, d);
      ml.insert(p, l);
      if (md.size() > K) begin
        void'(md.pop_back());
        void'(ml.pop_back());
      end
    end
  endfunction

  function automatic int unsigned model_vote();
    int c[L];
    int unsigned best;
    int bc;
    foreach (c[j]) c[j] = 0;
    foreach (ml[i]) if (ml[i] < L) c[ml[i]]++;
    best = 0;
    bc = 0;
    for (int j = 0; j < L; j++) begin
      if (c[j] > bc) begin
        bc = c[j];
        best = j;
      end
    end
    return best;
  endfunction

  function automatic logic [DW-1:0] model_worst();
    return (md.size() == K) ? DW'(md[K-1]) : ONES;
  endfunction

  task automatic do_insert(input int unsigned d, input int unsigned l);
    en_list = 1'b1;
    dist_entry = DW'(d);
    label_entry = LW'(l);
    tick();
    en_list = 1'b0;
    model_insert(d, l);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    md.delete();
    ml.delete();
  endtask

  // Pulses vote (en_list may already be driven by the caller) and measures
  // the cycle of label_valid relative to the accepting edge.
  task automatic do_vote(output logic [LW-1:0] lbl, output int lat, output bit rdy_low);
    vote = 1'b1;
    tick();
    vote = 1'b0;
    en_list = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (label_valid) begin
        lat = c;
        break;
      end
      if (ready) rdy_low = 1'b0;
      tick();
    end
    if (ready) rdy_low = 1'b0;
    lbl = label_out;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (nn_cnt !== 5'd0) begin failures++; $display("FAIL reset_nn_cnt got=%0d exp=0", nn_cnt); end
    checks++; if (worst_dist !== ONES) begin failures++; $display("FAIL reset_worst got=%h exp=%h", worst_dist, ONES); end
    checks++; if (label_out !== '0) begin failures++; $display("FAIL reset_label got=%0d exp=0", label_out); end
    checks++; if (label_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", label_valid); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sorted_insert();
    int unsigned ed[K] = '{10, 20, 30, 50};
    int unsigned el[K] = '{1, 3, 2, 0};
    do_insert(50, 0);
    checks++; if (worst_dist !== ONES) begin failures++; $display("FAIL partial_worst got=%h exp=%h", worst_dist, ONES); end
    do_insert(10, 1);
    do_insert(30, 2);
    do_insert(20, 3);
    for (int i = 0; i < K; i++) begin
      checks++; if (dut.dist_q[i] !== DW'(ed[i])) begin failures++; $display("FAIL sorted_dist[%0d] got=%0d exp=%0d", i, dut.dist_q[i], ed[i]); end
      checks++; if (dut.lbl_q[i] !== LW'(el[i])) begin failures++; $display("FAIL sorted_lbl[%0d] got=%0d exp=%0d", i, dut.lbl_q[i], el[i]); end
    end
    checks++; if (nn_cnt !== 5'd4) begin failures++; $display("FAIL sorted_nn_cnt got=%0d exp=4", nn_cnt); end
    checks++; if (worst_dist !== DW'(50)) begin failures++; $display("FAIL sorted_worst got=%0d exp=50", worst_dist); end
  endtask

  task automatic test_discard_and_tie();
    do_insert(60, 1);
    checks++; if (worst_dist !== DW'(50)) begin failures++; $display("FAIL discard_worst got=%0d exp=50", worst_dist); end
    checks++; if (dut.dist_q[3] !== DW'(50)) begin failures++; $display("FAIL discard_slot3 got=%0d exp=50", dut.dist_q[3]); end
    do_insert(25, 2);
    checks++; if (worst_dist !== DW'(30)) begin failures++; $display("FAIL ins25_worst got=%0d exp=30", worst_dist); end
    checks++; if (dut.dist_q[2] !== DW'(25) || dut.lbl_q[2] !== LW'(2)) begin
      failures++; $display("FAIL ins25_slot2 got=%0d/%0d exp=25/2", dut.dist_q[2], dut.lbl_q[2]);
    end
    do_insert(30, 1);
    checks++; if (worst_dist !== DW'(30)) begin failures++; $display("FAIL tie_worst got=%0d exp=30", worst_dist); end
    checks++; if (dut.lbl_q[3] !== LW'(2)) begin failures++; $display("FAIL tie_slot3_lbl got=%0d exp=2", dut.lbl_q[3]); end
    checks++; if (nn_cnt !== 5'd4) begin failures++; $display("FAIL tie_nn_cnt got=%0d exp=4", nn_cnt); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    checks++; if (nn_cnt !== 5'd0) begin failures++; $display("FAIL clr_nn_cnt got=%0d exp=0", nn_cnt); end
    en_list = 1'b1; dist_entry = 10; label_entry = 0;
    tick();
    dist_entry = 10; label_entry = 1;
    tick();
    en_list = 1'b0;
    model_insert(10, 0);
    model_insert(10, 1);
    checks++; if (dut.lbl_q[0] !== LW'(0) || dut.lbl_q[1] !== LW'(1)) begin
      failures++; $display("FAIL b2b_labels got=%0d,%0d exp=0,1", dut.lbl_q[0], dut.lbl_q[1]);
    end
    checks++; if (nn_cnt !== 5'd2) begin failures++; $display("FAIL b2b_nn_cnt got=%0d exp=2", nn_cnt); end
  endtask

  task automatic test_vote_tie();
    logic [LW-1:0] lbl;
    int lat;
    bit rl;
    do_clear();
    do_insert(1, 2);
    do_insert(2, 2);
    do_insert(3, 1);
    do_insert(4, 1);
    do_vote(lbl, lat, rl);
    checks++; if (lbl !== LW'(1)) begin failures++; $display("FAIL tie_vote_label got=%0d exp=1", lbl); end
    checks++; if (lat != K + L + 1) begin failures++; $display("FAIL vote_latency got=%0d exp=%0d", lat, K + L + 1); end
    checks++; if (rl !== 1'b1) begin failures++; $display("FAIL vote_ready_low got=%b exp=1", rl); end
    checks++; if (ready !== 1'b1 || label_valid !== 1'b0) begin
      failures++; $display("FAIL vote_after got=ready%b/valid%b exp=1/0", ready, label_valid);
    end
  endtask

  task automatic test_empty_and_invalid();
    logic [LW-1:0] lbl;
    int lat;
    bit rl;
    do_clear();
    do_vote(lbl, lat, rl);
    checks++; if (lbl !== LW'(0)) begin failures++; $display("FAIL empty_vote got=%0d exp=0", lbl); end
    checks++; if (lat != K + L + 1) begin failures++; $display("FAIL empty_latency got=%0d exp=%0d", lat, K + L + 1); end
    do_insert(5, 7);
    do_insert(6, 7);
    do_insert(7, 3);
    do_vote(lbl, lat, rl);
    checks++; if (lbl !== LW'(3)) begin failures++; $display("FAIL invalid_lbl_vote got=%0d exp=3", lbl); end
  endtask

  task automatic test_clr_mid_count();
    bit seen;
    vote = 1'b1;
    tick();
    vote = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    md.delete();
    ml.delete();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL clr_ready got=%b exp=1", ready); end
    checks++; if (nn_cnt !== 5'd0) begin failures++; $display("FAIL clr_mid_nn_cnt got=%0d exp=0", nn_cnt); end
    checks++; if (worst_dist !== ONES) begin failures++; $display("FAIL clr_worst got=%h exp=%h", worst_dist, ONES); end
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (label_valid) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL clr_no_pulse got=%b exp=0", seen); end
    checks++; if (label_out !== LW'(3)) begin failures++; $display("FAIL clr_label_hold got=%0d exp=3", label_out); end
  endtask

  task automatic test_random();
    logic [LW-1:0] lbl;
    int lat;
    bit rl;
    int unsigned d, l;
    for (int r = 0; r < 6; r++) begin
      do_clear();
      for (int n = 0; n < int'($urandom_range(3, 14)); n++) begin
        d = $urandom_range(0, 40);
        l = $urandom_range(0, 5);
        do_insert(d, l);
        checks++; if (nn_cnt !== 5'(md.size())) begin failures++; $display("FAIL rnd_nn_cnt got=%0d exp=%0d", nn_cnt, md.size()); end
        checks++; if (worst_dist !== model_worst()) begin failures++; $display("FAIL rnd_worst got=%h exp=%h", worst_dist, model_worst()); end
        for (int i = 0; i < md.size(); i++) begin
          checks++; if (dut.dist_q[i] !== DW'(md[i]) || dut.lbl_q[i] !== LW'(ml[i])) begin
            failures++; $display("FAIL rnd_slot[%0d] got=%0d/%0d exp=%0d/%0d", i, dut.dist_q[i], dut.lbl_q[i], md[i], ml[i]);
          end
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom_range(0, 40);
        l = $urandom_range(0, 3);
        en_list = 1'b1;
        dist_entry = DW'(d);
        label_entry = LW'(l);
        model_insert(d, l);
      end
      do_vote(lbl, lat, rl);
      checks++; if (lbl !== LW'(model_vote())) begin failures++; $display("FAIL rnd_vote got=%0d exp=%0d", lbl, model_vote()); end
      checks++; if (lat != K + L + 1) begin failures++; $display("FAIL rnd_latency got=%0d exp=%0d", lat, K + L + 1); end
      checks++; if (nn_cnt !== 5'(md.size())) begin failures++; $display("FAIL rnd_post_cnt got=%0d exp=%0d", nn_cnt, md.size()); end
    end
  endtask

  task automatic test_rst_mid_stream();
    do_clear();
    en_list = 1'b1;
    for (int n = 0; n < 3; n++) begin
      dist_entry = DW'($urandom_range(0, 100));
      label_entry = LW'($urandom_range(0, 3));
      tick();
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (nn_cnt !== 5'd0) begin failures++; $display("FAIL rst_nn_cnt got=%0d exp=0", nn_cnt); end
    checks++; if (worst_dist !== ONES) begin failures++; $display("FAIL rst_worst got=%h exp=%h", worst_dist, ONES); end
    checks++; if (label_out !== '0) begin failures++; $display("FAIL rst_label got=%0d exp=0", label_out); end
    checks++; if (ready !== 1'b1 || label_valid !== 1'b0) begin
      failures++; $display("FAIL rst_ctrl got=ready%b/valid%b exp=1/0", ready, label_valid);
    end
    en_list = 1'b0;
    tick();
    rst = 1'b0;
    md.delete();
    ml.delete();
    tick();
  endtask

  initial begin
    test_reset();
    test_sorted_insert();
    test_discard_and_tie();
    test_back_to_back();
    test_vote_tie();
    test_empty_and_invalid();
    test_clr_mid_count();
    test_random();
    test_rst_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
